// File: rtl/serial_addsub_pkg.sv
// Shared types and constants for the bit-serial adder/subtractor.
package serial_addsub_pkg;

    localparam int DEFAULT_WIDTH = 16;
    localparam int DEFAULT_CNT_W = $clog2(DEFAULT_WIDTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    function automatic int cnt_width(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/serial_addsub_16_fulladder.sv
// One-bit full adder used as the serial bit cell; purely combinational.
module fulladder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_addsub_16.sv
// Bit-serial unsigned add/subtract, one bit per cycle, result WIDTH cycles after accept.
// Optional saturation of the DONE result when SERIAL_ADDSUB_SAT_EN is defined.
module serial_addsub_16
    import serial_addsub_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             op_sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             flag,
    output logic             busy
);

    localparam int CNT_W = cnt_width(WIDTH);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   res_q, res_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               carry_q, carry_d;
    logic               sub_q, sub_d;
    logic               flag_q, flag_d;
    logic               fa_sum;
    logic               fa_cout;

    fulladder u_fa (
        .a    (a_q[0]),
        .b    (b_q[0]),
        .cin  (carry_q),
        .sum  (fa_sum),
        .cout (fa_cout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            sub_q   <= 1'b0;
            flag_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            sub_q   <= sub_d;
            flag_q  <= flag_d;
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        sub_d   = sub_q;
        flag_d  = flag_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    // Subtract is a + ~b + 1: invert b here and seed the carry with 1.
                    a_d     = a;
                    b_d     = op_sub ? ~b : b;
                    sub_d   = op_sub;
                    carry_d = op_sub;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                res_d   = {fa_sum, res_q[WIDTH-1:1]};
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                carry_d = fa_cout;
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    flag_d  = fa_cout ^ sub_q;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign in_ready  = rst_n && (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign flag      = flag_q;

`ifdef SERIAL_ADDSUB_SAT_EN
    // Overflow clamps to all-ones for add, underflow clamps to zero for subtract.
    assign result = ((state_q == DONE) && flag_q) ? (sub_q ? '0 : '1) : res_q;
`else
    assign result = res_q;
`endif

endmodule

// File: tb/tb_serial_addsub_16.sv
// Directed self-checking bench for serial_addsub_16 (WIDTH=16).
module tb_serial_addsub_16;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic        op_sub;
    logic [15:0] a;
    logic [15:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] result;
    logic        flag;
    logic        busy;

    int n_checks;
    int n_errors;
    int cyc;

    serial_addsub_16 #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_sub    (op_sub),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .flag      (flag),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [16:0] ref_model(input logic [15:0] x, input logic [15:0] y,
                                              input logic sub);
        logic [16:0] s;
        logic [15:0] r;
        logic        f;
        if (sub) begin
            r = x - y;
            f = (x < y);
        end else begin
            s = {1'b0, x} + {1'b0, y};
            r = s[15:0];
            f = s[16];
        end
`ifdef SERIAL_ADDSUB_SAT_EN
        if (f) r = sub ? 16'h0000 : 16'hFFFF;
`endif
        return {f, r};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input string tag, input logic [15:0] opa, input logic [15:0] opb,
                          input logic sub, input logic [15:0] exp_res, input logic exp_flag);
        int lat;
        a        = opa;
        b        = opb;
        op_sub   = sub;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk({tag, "_busy"}, busy, 1);
        lat = 0;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (out_valid) begin
                lat = i;
                break;
            end
        end
        chk({tag, "_lat"}, lat, 16);
        chk({tag, "_res"}, result, exp_res);
        chk({tag, "_flag"}, flag, exp_flag);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({tag, "_ovld_clr"}, out_valid, 0);
        chk({tag, "_irdy"}, in_ready, 1);
    endtask

    logic [15:0] hold_res;
    logic        hold_flag;
    int          seen;
    int          lat;
    int          acc_cyc[4];
    logic [15:0] va[4];
    logic [15:0] vb[4];
    logic        vs[4];
    logic [16:0] exp_v;

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        op_sub    = 1'b0;
        a         = '0;
        b         = '0;
        out_ready = 1'b0;

        repeat (3) tick();
        chk("rst_ovld", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_res", result, 0);
        chk("rst_flag", flag, 0);
        rst_n = 1'b1;
        tick();
        chk("rst_irdy", in_ready, 1);

        run_op("add_5_3", 16'h0005, 16'h0003, 1'b0, 16'h0008, 1'b0);
`ifdef SERIAL_ADDSUB_SAT_EN
        run_op("add_wrap", 16'hFFFF, 16'h0001, 1'b0, 16'hFFFF, 1'b1);
`else
        run_op("add_wrap", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1);
`endif
        run_op("sub_eq", 16'h1234, 16'h1234, 1'b1, 16'h0000, 1'b0);
        run_op("add_mid", 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0);

        // Held result in DONE with a competing in_valid waiting.
        a = 16'h0003; b = 16'h0005; op_sub = 1'b1; in_valid = 1'b1;
        tick();
        a = 16'h1234; b = 16'h1234; op_sub = 1'b1;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (out_valid) begin
                seen = 1;
                break;
            end
        end
        chk("hold_seen", seen, 1);
`ifdef SERIAL_ADDSUB_SAT_EN
        chk("hold_res0", result, 16'h0000);
`else
        chk("hold_res0", result, 16'hFFFE);
`endif
        chk("hold_flag0", flag, 1);
        hold_res  = result;
        hold_flag = flag;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("hold_res", result, hold_res);
            chk("hold_flag", flag, hold_flag);
            chk("hold_ovld", out_valid, 1);
            chk("hold_irdy", in_ready, 0);
            chk("hold_busy", busy, 1);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("cons_irdy", in_ready, 1);
        chk("cons_busy", busy, 0);
        tick();
        in_valid = 1'b0;
        chk("next_acc_busy", busy, 1);
        seen = 0;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (out_valid) begin
                seen = i;
                break;
            end
        end
        chk("next_lat", seen, 16);
        chk("next_res", result, 16'h0000);
        chk("next_flag", flag, 0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // Reset in the middle of SHIFT.
        a = 16'hF0F0; b = 16'h0F0F; op_sub = 1'b0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (8) tick();
        chk("mid_busy_pre", busy, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ovld", out_valid, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_res", result, 0);
        chk("mid_rst_flag", flag, 0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("mid_rst_irdy", in_ready, 1);
        seen = 0;
        for (int i = 0; i < 25; i++) begin
            tick();
            if (out_valid) seen = 1;
        end
        chk("mid_rst_stale", seen, 0);

        // Back-to-back with in_valid and out_ready held high.
        va[0] = 16'h00FF; vb[0] = 16'h0F01; vs[0] = 1'b0;
        va[1] = 16'h8000; vb[1] = 16'h0001; vs[1] = 1'b1;
        va[2] = 16'h0001; vb[2] = 16'h8000; vs[2] = 1'b1;
        va[3] = 16'hABCD; vb[3] = 16'h5433; vs[3] = 1'b0;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int k = 0; k < 4; k++) begin
            a = va[k]; b = vb[k]; op_sub = vs[k];
            seen = 0;
            for (int i = 0; i < 40; i++) begin
                if (in_ready) begin
                    seen = 1;
                    break;
                end
                tick();
            end
            chk("b2b_irdy_seen", seen, 1);
            @(posedge clk);
            acc_cyc[k] = cyc;
            #1;
            if (k > 0) chk("b2b_period", acc_cyc[k] - acc_cyc[k-1], 18);
            lat = 0;
            for (int i = 1; i <= 40; i++) begin
                tick();
                if (out_valid) begin
                    lat = i;
                    break;
                end
            end
            if (k == 3) in_valid = 1'b0;
            exp_v = ref_model(va[k], vb[k], vs[k]);
            chk("b2b_lat", lat, 16);
            chk("b2b_res", result, exp_v[15:0]);
            chk("b2b_flag", flag, exp_v[16]);
        end
        tick();
        out_ready = 1'b0;
        chk("b2b_end_idle", busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
